fetch_sequencer: RTL and testbench

//  Upstream neighbour of the control decoder. Fetches instruction bytes, holds the

---
 rtl/fetch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// fetch_sequencer
//
// Fetches instruction bytes, holds the instruction register and sequences one-
// and two-cycle instructions for the downstream control decoder. Owns the PC,
// the link (return address) register and the carry flag, and redirects the PC
// from the decoder's J / LJ / LJR outputs.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and address (address is always pc)
//   imem_rdata/ready  fetched byte and its handshake acknowledge
//   dmem_ready        data-memory ack that completes the second exec cycle
//   J, LJ, LJR, MC,   decoder controls: conditional jump, long jump, long jump
//   WC                with link save, memory instruction, write carry
//   alu_carry         ALU carry-out, captured into carry when WC acts
//   jump_target       destination for J / LJ
//   inst, cycle,      registered instruction byte, exec cycle index and carry
//   carry             flag, fed back to the decoder
//   exec_en           commit strobe for datapath writes
//   pc, link          next-instruction address and saved return address
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              dmem_ready,
  input  logic              J,
  input  logic              LJ,
  input  logic              LJR,
  input  logic              MC,
  input  logic              WC,
  input  logic              alu_carry,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [7:0]        inst,
  output logic              cycle,
  output logic              carry,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link
);

  // Code 2'b11 is unused and falls back to FETCH through the default arm.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC0 = 2'b01,
    ST_EXEC1 = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [7:0]        inst_q, inst_d;
  logic              cycle_q, cycle_d;
  logic              carry_q, carry_d;
  // run_q keeps imem_req low until the first clock after reset release, so
  // no fetch can be accepted in the same cycle reset is removed.
  logic              run_q, run_d;

  // Next-state, register updates and combinational strobes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    link_d   = link_q;
    inst_d   = inst_q;
    cycle_d  = 1'b0;
    carry_d  = carry_q;
    run_d    = 1'b1;
    imem_req = 1'b0;
    exec_en  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = run_q;
        if (run_q && imem_ready) begin
          inst_d  = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC0;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC0: begin
        exec_en = 1'b1;
        if (WC) begin
          carry_d = alu_carry;
        end else begin
          carry_d = carry_q;
        end
        // LJ overrides J here: J is only decoded in the second cycle.
        if (LJ) begin
          pc_d = jump_target;
          if (LJR) begin
            link_d = pc_q;
          end else begin
            link_d = link_q;
          end
        end else begin
          pc_d = pc_q;
        end
        if (MC) begin
          state_d = ST_EXEC1;
          cycle_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC1: begin
        exec_en = dmem_ready;
        if (dmem_ready) begin
          if (J) begin
            pc_d = jump_target;
          end else begin
            pc_d = pc_q;
          end
          if (WC) begin
            carry_d = alu_carry;
          end else begin
            carry_d = carry_q;
          end
          state_d = ST_FETCH;
        end else begin
          cycle_d = 1'b1;
          state_d = ST_EXEC1;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      link_q  <= {ADDR_W{1'b0}};
      inst_q  <= 8'h00;
      cycle_q <= 1'b0;
      carry_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      inst_q  <= inst_d;
      cycle_q <= cycle_d;
      carry_q <= carry_d;
      run_q   <= run_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign link      = link_q;
  assign inst      = inst_q;
  assign cycle     = cycle_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
//------------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. An instruction-level reference model
// (pc, carry, link, inst) is advanced one phase at a time; every clock the
// visible outputs are compared against it. Inputs are driven 1 ns after the
// rising edge and outputs sampled 1 ns later.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        dmem_ready;
  logic        J, LJ, LJR, MC, WC;
  logic        alu_carry;
  logic [15:0] jump_target;
  logic [7:0]  inst;
  logic        cycle;
  logic        carry;
  logic        exec_en;
  logic [15:0] pc;
  logic [15:0] link;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] m_pc;
  logic [15:0] m_link;
  logic        m_carry;
  logic [7:0]  m_inst;

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .dmem_ready(dmem_ready),
    .J(J), .LJ(LJ), .LJR(LJR), .MC(MC), .WC(WC),
    .alu_carry(alu_carry), .jump_target(jump_target),
    .inst(inst), .cycle(cycle), .carry(carry), .exec_en(exec_en),
    .pc(pc), .link(link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_controls();
    J           = 1'($urandom);
    LJ          = 1'($urandom);
    LJR         = 1'($urandom);
    MC          = 1'($urandom);
    WC          = 1'($urandom);
    alu_carry   = 1'($urandom);
    jump_target = 16'($urandom);
  endtask

  // Compare registered architectural state against the model.
  task automatic check_arch(input string tag);
    checks++;
    if ({pc, carry, link, inst} !== {m_pc, m_carry, m_link, m_inst}) begin
      errors++;
      $display("FAIL %s_arch: got pc=%h carry=%b link=%h inst=%h expected pc=%h carry=%b link=%h inst=%h",
               tag, pc, carry, link, inst, m_pc, m_carry, m_link, m_inst);
    end
  endtask

  // Assert reset at any point, check asynchronous values, release, and check
  // that fetching starts at RESET_PC on the following clock.
  task automatic apply_reset(input string tag);
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    checks++;
    if ({pc, inst, cycle, carry, link, exec_en, imem_req} !== {16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_async: got pc=%h inst=%h cycle=%b carry=%b link=%h exec_en=%b req=%b expected all zero",
               tag, pc, inst, cycle, carry, link, exec_en, imem_req);
    end
    next_edge();
    rst_n = 1'b1;
    m_pc = 16'h0000; m_link = 16'h0000; m_carry = 1'b0; m_inst = 8'h00;
    next_edge();
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL %s_first_fetch: got req=%b addr=%h expected req=1 addr=0000", tag, imem_req, imem_addr);
    end
  endtask

  // FETCH: 'stalls' clocks with imem_ready low, then the byte is delivered.
  task automatic fetch_phase(input int stalls, input logic [7:0] b);
    for (int i = 0; i <= stalls; i++) begin
      junk_controls();
      dmem_ready = 1'($urandom);
      imem_ready = (i == stalls);
      imem_rdata = (i == stalls) ? b : 8'($urandom);
      #1;
      checks++;
      if ({imem_req, imem_addr, exec_en, cycle} !== {1'b1, m_pc, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL fetch_ctl: got req=%b addr=%h exec_en=%b cycle=%b expected req=1 addr=%h exec_en=0 cycle=0",
                 imem_req, imem_addr, exec_en, cycle, m_pc);
      end
      check_arch("fetch");
      next_edge();
    end
    m_inst = b;
    m_pc   = m_pc + 16'h0001;
  endtask

  // EXEC0: one clock; J is driven randomly and must be ignored.
  task automatic exec0(input logic wc, input logic lj, input logic ljr, input logic mc,
                       input logic ac, input logic [15:0] jt);
    WC = wc; LJ = lj; LJR = ljr; MC = mc; alu_carry = ac; jump_target = jt;
    J          = 1'($urandom);
    dmem_ready = 1'($urandom);
    imem_ready = 1'($urandom);
    imem_rdata = 8'($urandom);
    #1;
    checks++;
    if ({cycle, exec_en, imem_req} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL exec0_ctl: got cycle=%b exec_en=%b req=%b expected cycle=0 exec_en=1 req=0",
               cycle, exec_en, imem_req);
    end
    check_arch("exec0");
    next_edge();
    if (wc) m_carry = ac;
    if (lj) begin
      if (ljr) m_link = m_pc;
      m_pc = jt;
    end
  endtask

  // EXEC1: 'waits' clocks with dmem_ready low, then the completing clock.
  task automatic exec1(input int waits, input logic j, input logic wc,
                       input logic ac, input logic [15:0] jt);
    for (int i = 0; i <= waits; i++) begin
      junk_controls();
      imem_ready = 1'($urandom);
      if (i == waits) begin
        J = j; WC = wc; alu_carry = ac; jump_target = jt;
      end
      dmem_ready = (i == waits);
      #1;
      checks++;
      if ({cycle, exec_en, imem_req} !== {1'b1, (i == waits), 1'b0}) begin
        errors++;
        $display("FAIL exec1_ctl: got cycle=%b exec_en=%b req=%b expected cycle=1 exec_en=%b req=0",
                 cycle, exec_en, imem_req, (i == waits));
      end
      check_arch("exec1");
      next_edge();
    end
    if (j)  m_pc    = jt;
    if (wc) m_carry = ac;
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_fetch_stall();
    fetch_phase(3, 8'h45);
    checks++;
    if ({inst, pc} !== {8'h45, 16'h0001}) begin
      errors++;
      $display("FAIL stall_inst_pc: got inst=%h pc=%h expected inst=45 pc=0001", inst, pc);
    end
    exec0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    fetch_phase(0, 8'h01);
    exec0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_mem_instr();
    fetch_phase(1, 8'h85);
    exec0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    exec1(2, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_jump();
    fetch_phase(0, 8'hE0);
    exec0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    exec1(0, 1'b1, 1'b0, 1'b0, 16'h1234);
    #1;
    checks++;
    if (imem_addr !== 16'h1234) begin
      errors++;
      $display("FAIL jump_taken: got addr=%h expected 1234", imem_addr);
    end
    fetch_phase(0, 8'hE0);
    exec0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    exec1(1, 1'b0, 1'b0, 1'b0, 16'h5555);
    #1;
    checks++;
    if (imem_addr !== 16'h1235) begin
      errors++;
      $display("FAIL jump_not_taken: got addr=%h expected 1235", imem_addr);
    end
  endtask

  task automatic test_long_jump();
    fetch_phase(0, 8'h10);
    exec0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    fetch_phase(0, 8'hC0);
    exec0(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200);
    #1;
    checks++;
    if ({link, imem_addr} !== {16'h0011, 16'h0200}) begin
      errors++;
      $display("FAIL long_jump: got link=%h addr=%h expected link=0011 addr=0200", link, imem_addr);
    end
  endtask

  task automatic test_carry_reset();
    fetch_phase(0, 8'h31);
    exec0(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    #1;
    checks++;
    if (carry !== 1'b1) begin
      errors++;
      $display("FAIL carry_set: got carry=%b expected 1", carry);
    end
    fetch_phase(0, 8'h85);
    exec0(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0777);
    // Now in EXEC1 with pending updates; reset must discard them.
    dmem_ready = 1'b1; WC = 1'b1; alu_carry = 1'b1; J = 1'b1; jump_target = 16'h4321;
    apply_reset("reset_exec1");
    fetch_phase(0, 8'h00);
    exec0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_wrap();
    fetch_phase(0, 8'hC0);
    exec0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    fetch_phase(1, 8'h07);
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h expected 0000", pc);
    end
    exec0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      logic mc;
      mc = 1'($urandom);
      fetch_phase(($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0, 8'($urandom));
      exec0(1'($urandom), ($urandom % 4 == 0), 1'($urandom), mc, 1'($urandom), 16'($urandom));
      if (mc) begin
        exec1(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_rdata = 8'h00; imem_ready = 1'b0; dmem_ready = 1'b0;
    J = 1'b0; LJ = 1'b0; LJR = 1'b0; MC = 1'b0; WC = 1'b0;
    alu_carry = 1'b0; jump_target = 16'h0000;
    m_pc = 16'h0000; m_link = 16'h0000; m_carry = 1'b0; m_inst = 8'h00;
    next_edge();
    test_reset();
    test_fetch_stall();
    test_mem_instr();
    test_jump();
    test_long_jump();
    test_carry_reset();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
